serial_compare_controller: RTL and testbench

Sequencer for the bit-serial compare datapath. It captures two WIDTH-bit operands on a start pulse and shifts them out one bit per clock, LSB-first or MSB-first. It feeds each bit pair into an internal bit-serial comparator and reports a one-hot L/E/G result with a done pulse. It replaces hand-timed testbench sequencing of the parallel-in/serial-out shifters and the comparator's `op` switch with a start/busy/done handshake.

---
 rtl/serial_cmp_pkg.sv | 37 +++
 rtl/serial_cmp_core.sv | 49 ++++
 rtl/serial_compare_controller.sv | 176 +++++++++++++++++
 tb/tb_serial_compare_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// -----------------------------------------------------------------------------
// serial_cmp_pkg
// Shared types and constants for the bit-serial compare controller.
//   state_e       : controller FSM states (IDLE, SHIFT, DONE)
//   rel_e         : running relation between operands A and B (EQ, LT, GT)
//   DEFAULT_WIDTH : default operand width
//   rel_to_leg    : converts a relation to the one-hot {L, E, G} result
// -----------------------------------------------------------------------------
package serial_cmp_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        EQ = 2'd0,
        LT = 2'd1,
        GT = 2'd2
    } rel_e;

    // One-hot result ordered {L, E, G}.
    function automatic logic [2:0] rel_to_leg(input rel_e rel);
        logic [2:0] leg;
        leg = 3'b010;
        case (rel)
            LT:      leg = 3'b100;
            GT:      leg = 3'b001;
            default: leg = 3'b010;
        endcase
        return leg;
    endfunction

endpackage : serial_cmp_pkg

// File: rtl/serial_cmp_core.sv
// -----------------------------------------------------------------------------
// serial_cmp_core
// Running-relation register of the bit-serial comparator. One bit pair is
// folded into the relation on every enabled cycle.
//   LSB-first : any differing pair overwrites the relation (last one wins).
//   MSB-first : only the first differing pair sets the relation.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous, active-low reset
//   clear     in   restart the relation at EQ (new operation)
//   en        in   consume a_bit/b_bit this cycle
//   msb_first in   bit order of the current operation
//   a_bit     in   current bit of operand A
//   b_bit     in   current bit of operand B
//   rel       out  running relation of A versus B
// -----------------------------------------------------------------------------
module serial_cmp_core
    import serial_cmp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    input  logic msb_first,
    input  logic a_bit,
    input  logic b_bit,
    output rel_e rel
);

    logic differ;
    logic may_update;

    assign differ     = a_bit ^ b_bit;
    // MSB-first locks the relation at the first difference.
    assign may_update = !msb_first || (rel == EQ);

    // NOTE: state registers use non-blocking (<=) assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rel <= EQ;
        end else if (clear) begin
            rel <= EQ;
        end else if (en && differ && may_update) begin
            rel <= a_bit ? GT : LT;
        end
    end

endmodule : serial_cmp_core

// File: rtl/serial_compare_controller.sv
// -----------------------------------------------------------------------------
// serial_compare_controller
// Captures two WIDTH-bit operands on a start pulse, shifts them out one bit
// pair per clock (LSB-first or MSB-first) into serial_cmp_core, and reports a
// one-hot L/E/G result together with a one-cycle done pulse.
//
// Optional feature: define SIGNED_CMP_EN to add the is_signed port. When
// is_signed is captured as 1 and the operand sign bits differ, the sign
// decides the result. Without the macro every compare is unsigned.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-low reset
//   start      in   request, sampled only in IDLE or DONE
//   a_in,b_in  in   operands, captured when start is accepted
//   msb_first  in   bit order captured with the operands (0 = LSB-first)
//   is_signed  in   two's-complement compare (SIGNED_CMP_EN only)
//   busy       out  high while pairs are being shifted
//   done       out  one-cycle pulse, L/E/G valid
//   ser_a,ser_b out bit pair consumed this cycle, 0 outside SHIFT
//   L,E,G      out  A<B, A==B, A>B
//
// Timing: start accepted at edge k -> SHIFT for WIDTH cycles, DONE state for
// one cycle, and done/L/E/G register at edge k+WIDTH+1. A start seen in the
// DONE state is accepted at that same edge, giving one result every WIDTH+1
// cycles with no gap.
// -----------------------------------------------------------------------------
module serial_compare_controller
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             msb_first,
`ifdef SIGNED_CMP_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic             ser_a,
    output logic             ser_b,
    output logic             L,
    output logic             E,
    output logic             G
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state;
    state_e             state_next;
    logic [WIDTH-1:0]   sh_a;
    logic [WIDTH-1:0]   sh_b;
    logic [CNT_W-1:0]   cnt;
    logic               msb_q;
    logic               accept;
    logic               last_pair;
    logic               in_shift;
    logic               a_bit;
    logic               b_bit;
    rel_e               rel;
    rel_e               rel_final;

    assign in_shift  = (state == SHIFT);
    assign accept    = ((state == IDLE) || (state == DONE)) && start;
    assign last_pair = in_shift && (cnt == CNT_W'(WIDTH - 1));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_pair) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------- datapath
    // The next pair always sits at the outgoing end of each shift register:
    // bit 0 for LSB-first (shift right), bit WIDTH-1 for MSB-first (shift left).
    // NOTE: the shift registers are plain flops, not a memory, so they take
    // the asynchronous reset like every other register here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_a  <= '0;
            sh_b  <= '0;
            cnt   <= '0;
            msb_q <= 1'b0;
        end else if (accept) begin
            sh_a  <= a_in;
            sh_b  <= b_in;
            cnt   <= '0;
            msb_q <= msb_first;
        end else if (in_shift) begin
            sh_a  <= msb_q ? {sh_a[WIDTH-2:0], 1'b0} : {1'b0, sh_a[WIDTH-1:1]};
            sh_b  <= msb_q ? {sh_b[WIDTH-2:0], 1'b0} : {1'b0, sh_b[WIDTH-1:1]};
            cnt   <= cnt + CNT_W'(1);
        end
    end

    assign a_bit = msb_q ? sh_a[WIDTH-1] : sh_a[0];
    assign b_bit = msb_q ? sh_b[WIDTH-1] : sh_b[0];
    assign ser_a = in_shift && a_bit;
    assign ser_b = in_shift && b_bit;
    assign busy  = in_shift;

    serial_cmp_core u_core (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .en        (in_shift),
        .msb_first (msb_q),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .rel       (rel)
    );

    // ----------------------------------------------------- sign override
`ifdef SIGNED_CMP_EN
    // Sign bits are kept aside because the shift registers lose them.
    logic signed_q;
    logic sign_a;
    logic sign_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            signed_q <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
        end else if (accept) begin
            signed_q <= is_signed;
            sign_a   <= a_in[WIDTH-1];
            sign_b   <= b_in[WIDTH-1];
        end
    end

    always_comb begin
        rel_final = rel;
        if (signed_q && (sign_a != sign_b)) begin
            rel_final = sign_a ? LT : GT;
        end
    end
`else
    assign rel_final = rel;
`endif

    // ----------------------------------------------------- result latch
    // The relation is final once the DONE state is reached; it is latched at
    // the edge that closes DONE so done and L/E/G appear together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done      <= 1'b0;
            {L, E, G} <= 3'b000;
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                {L, E, G} <= rel_to_leg(rel_final);
            end
        end
    end

endmodule : serial_compare_controller

// File: tb/tb_serial_compare_controller.sv
// -----------------------------------------------------------------------------
// tb_serial_compare_controller
// Directed-vector bench with a scoreboard. Each accepted start pushes its
// expected {L,E,G} and done cycle into a queue; a monitor on the falling edge
// pops on done and also tracks busy, the serial bit stream and result hold.
// Build with +define+SIGNED_CMP_EN to exercise the signed compare.
// -----------------------------------------------------------------------------
module tb_serial_compare_controller;

    localparam int W = 32;
    localparam logic [2:0] RES_L = 3'b100;
    localparam logic [2:0] RES_E = 3'b010;
    localparam logic [2:0] RES_G = 3'b001;

    typedef struct {
        logic [2:0] leg;
        int         done_cyc;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         msb_first;
`ifdef SIGNED_CMP_EN
    logic         is_sgn;
`endif
    logic         busy;
    logic         done;
    logic         ser_a;
    logic         ser_b;
    logic         L;
    logic         E;
    logic         G;

    int           tests;
    int           fails;
    int           cyc;
    exp_t         exp_q[$];

    // Operation currently being shifted, as seen by the monitor.
    logic         cur_valid;
    logic [W-1:0] cur_a;
    logic [W-1:0] cur_b;
    logic         cur_msb;
    int           cur_k;
    logic [2:0]   last_leg;

    serial_compare_controller #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .msb_first (msb_first),
`ifdef SIGNED_CMP_EN
        .is_signed (is_sgn),
`endif
        .busy      (busy),
        .done      (done),
        .ser_a     (ser_a),
        .ser_b     (ser_b),
        .L         (L),
        .E         (E),
        .G         (G)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------ monitor
    always @(negedge clk) begin
        if (rst) begin
            int   idx;
            logic exp_busy;
            exp_t e;
            idx      = cyc - cur_k;
            exp_busy = cur_valid && (idx >= 0) && (idx < W);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("result_leg", 64'({L, E, G}), 64'(e.leg));
                    check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                    last_leg = e.leg;
                end
            end else begin
                check("leg_hold", 64'({L, E, G}), 64'(last_leg));
            end
            check("busy", 64'(busy), 64'(exp_busy));
            if (exp_busy) begin
                check("ser_a", 64'(ser_a), 64'(cur_msb ? cur_a[W-1-idx] : cur_a[idx]));
                check("ser_b", 64'(ser_b), 64'(cur_msb ? cur_b[W-1-idx] : cur_b[idx]));
            end else begin
                check("ser_idle", 64'({ser_a, ser_b}), 64'(0));
            end
        end
    end

    // ------------------------------------------------------------ driver
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic msb);
        a_in      = a;
        b_in      = b;
        msb_first = msb;
        start     = 1'b1;
    endtask

    // Called #1 after the edge that accepted the start.
    task automatic note_accept(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic msb, input logic [2:0] leg);
        exp_t e;
        cur_a     = a;
        cur_b     = b;
        cur_msb   = msb;
        cur_k     = cyc;
        cur_valid = 1'b1;
        e.leg      = leg;
        e.done_cyc = cyc + W + 1;
        exp_q.push_back(e);
    endtask

    task automatic wait_results();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("result_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic msb,
                          input logic [2:0] leg, input bit pulse_mid);
        @(posedge clk);
        #1;
        drive(a, b, msb);
        @(posedge clk);
        #1;
        start = 1'b0;
        note_accept(a, b, msb, leg);
        if (pulse_mid) begin
            // A start and fresh operands during SHIFT must change nothing.
            repeat (5) @(posedge clk);
            #1;
            drive(~a, ~b, ~msb);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_results();
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        tests     = 0;
        fails     = 0;
        cyc       = 0;
        cur_valid = 1'b0;
        cur_k     = 0;
        cur_a     = '0;
        cur_b     = '0;
        cur_msb   = 1'b0;
        last_leg  = 3'b000;
        rst       = 1'b0;
        start     = 1'b0;
        a_in      = '0;
        b_in      = '0;
        msb_first = 1'b0;
`ifdef SIGNED_CMP_EN
        is_sgn    = 1'b0;
`endif
        #3;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_ser",  64'({ser_a, ser_b}), 64'(0));
        check("reset_leg",  64'({L, E, G}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // -1 vs 123 unsigned: 0xFFFFFFFF is larger; top bit is last to differ.
        run_op(32'hFFFF_FFFF, 32'd123, 1'b0, RES_G, 1'b0);
`ifdef SIGNED_CMP_EN
        is_sgn = 1'b1;
        run_op(32'hFFFF_FFFF, 32'd123, 1'b1, RES_L, 1'b0);
        is_sgn = 1'b0;
        run_op(32'hFFFF_FFFF, 32'd123, 1'b1, RES_G, 1'b0);
        // Same sign bits: signed compare falls back to the magnitude order.
        is_sgn = 1'b1;
        run_op(32'hFFFF_FFF0, 32'hFFFF_FFFE, 1'b0, RES_L, 1'b0);
        is_sgn = 1'b0;
`else
        run_op(32'hFFFF_FFFF, 32'd123, 1'b1, RES_G, 1'b0);
`endif
        // Equal operands in both orders.
        run_op(32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b0, RES_E, 1'b0);
        run_op(32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b1, RES_E, 1'b0);
        // 5 > 3 MSB-first, then 2 < 3 LSB-first; result holds in between.
        run_op(32'd5, 32'd3, 1'b1, RES_G, 1'b0);
        run_op(32'd2, 32'd3, 1'b0, RES_L, 1'b1);
        // First difference (MSB-first) vs last difference (LSB-first) wins.
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, RES_G, 1'b0);
        run_op(32'h0000_0001, 32'h8000_0000, 1'b1, RES_L, 1'b0);

        // Reset during the 10th SHIFT cycle: everything clears, no done.
        @(posedge clk);
        #1;
        drive(32'd7, 32'd9, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        note_accept(32'd7, 32'd9, 1'b0, RES_L);
        repeat (9) @(posedge clk);
        #2;
        cur_valid = 1'b0;
        exp_q.delete();
        last_leg  = 3'b000;
        rst       = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_ser",  64'({ser_a, ser_b}), 64'(0));
        check("abort_leg",  64'({L, E, G}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        run_op(32'd9, 32'd7, 1'b1, RES_G, 1'b0);

        // Back-to-back: start held high, operands/order changed mid-SHIFT.
        @(posedge clk);
        #1;
        drive(32'hFFFF_FFFF, 32'd123, 1'b0);
        @(posedge clk);
        #1;
        note_accept(32'hFFFF_FFFF, 32'd123, 1'b0, RES_G);
        a_in      = 32'h0000_0001;
        b_in      = 32'h8000_0000;
        msb_first = 1'b1;
        repeat (W + 1) @(posedge clk);
        #1;
        note_accept(32'h0000_0001, 32'h8000_0000, 1'b1, RES_L);
        start = 1'b0;
        wait_results();

        repeat (3) @(posedge clk);
        #1;
        check("pending_results", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_serial_compare_controller
